serial_tx_8n1: RTL and testbench

//  - Transmit end of the lab serial link: takes one parallel word per valid/ready handshake and

---
 rtl/serial_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 31 +++
 rtl/serial_tx_8n1.sv | 96 +++++++++
 tb/tb_serial_tx_8n1.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the lab serial link (TX and RX sides).
// State encodings and line levels must stay identical on both ends.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } serial_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: pulses tick for one cycle when the count reaches CLK_DIV-1.
// The count is held at zero whenever en is low.
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/serial_tx_8n1.sv
// Serial transmitter: accepts one word per valid/ready handshake and sends
// it as start bit, DATA_W data bits LSB first, and one stop bit.
module serial_tx_8n1
    import serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned IDX_W = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    serial_state_t     state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_tick;
    logic              accept;

    assign accept     = tx_valid && (state == ST_IDLE);
    assign shift_next = shift_reg >> 1;

    // Timer runs for the whole frame; it is cleared only while idle, so the
    // first start-bit cycle always begins a fresh bit period.
    baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= LINE_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx      <= LINE_IDLE;
                    bit_idx <= '0;
                    if (accept) begin
                        shift_reg <= tx_data;
                        tx        <= START_LVL;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx    <= shift_reg[0];
                        state <= ST_DATA;
                    end
                end
                // tx is registered, so the next bit is driven from the
                // post-shift value on the same edge the shift happens.
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == IDX_LAST) begin
                            tx    <= LINE_IDLE;
                            state <= ST_STOP;
                        end else begin
                            shift_reg <= shift_next;
                            tx        <= shift_next[0];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    tx <= LINE_IDLE;
                    if (bit_tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= LINE_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_8n1.sv
// Bench for serial_tx_8n1: a line-sampling receiver model decodes every frame
// and compares it against words queued when the handshake completed.
module tb_serial_tx_8n1;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;
    localparam int FRAME   = (DATA_W + 2) * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready;
    logic        tx;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int frames_rx = 0;
    int last_high_run = 0;

    always #5 clk = ~clk;

    serial_tx_8n1 #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: records one sample per clock for a whole frame, then
    // checks that every bit is held for exactly CLK_DIV cycles.
    logic [FRAME-1:0] samp;
    int  pos = -1;
    int  high_run = 0;
    bit  busy_bad = 0;
    always @(negedge clk) begin
        if (rst) begin
            pos = -1;
            high_run = 0;
        end else if (pos < 0) begin
            if (tx === 1'b0) begin
                last_high_run = high_run;
                samp[0] = 1'b0;
                busy_bad = (busy !== 1'b1);
                pos = 1;
            end else begin
                high_run++;
            end
        end else begin
            samp[pos] = tx;
            if (busy !== 1'b1 || tx_ready !== 1'b0) busy_bad = 1;
            pos++;
            if (pos == FRAME) begin
                logic [7:0] rx_byte;
                bit hold_bad;
                hold_bad = 0;
                for (int b = 0; b < DATA_W + 2; b++)
                    for (int k = 1; k < CLK_DIV; k++)
                        if (samp[b*CLK_DIV+k] !== samp[b*CLK_DIV]) hold_bad = 1;
                for (int i = 0; i < DATA_W; i++) rx_byte[i] = samp[(i+1)*CLK_DIV];
                check("bit_hold", 32'(hold_bad), 32'd0);
                check("stop_bit", 32'(samp[FRAME-1]), 32'd1);
                check("busy_in_frame", 32'(busy_bad), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
                frames_rx++;
                pos = -1;
                high_run = 0;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit expect_rx);
        @(negedge clk);
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = d;
        if (expect_rx) exp_q.push_back(d);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int cyc;

        // Reset with a word offered: nothing may be accepted or sent.
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_frame", 32'(busy), 32'd0);

        // Single word: busy for exactly the frame length, ready on the next cycle.
        send(8'hA5, 1);
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cyc), 32'(FRAME));
        check("ready_after", 32'(tx_ready), 32'd1);
        @(negedge clk);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        wait_ready();
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_idle();
        check("gap_high_cycles", 32'(CLK_DIV + last_high_run), 32'(CLK_DIV + 1));

        // Valid pulse during DATA state is ignored.
        send(8'h81, 1);
        repeat (10) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        check("ready_in_data", 32'(tx_ready), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        // Data change after acceptance has no effect.
        send(8'h12, 1);
        @(posedge clk);
        #1 tx_data = 8'hFF;
        wait_idle();

        // Reset at frame cycle 15 aborts the frame.
        send(8'hC3, 0);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'h01, 1);
        wait_idle();

        check("frames_rx", 32'(frames_rx), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
